dm_responder: RTL
=================

Name: dm_responder

Overview:
- Data-memory responder for the M-stage port of the pipelined CPU: the slave end of the m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata interface.
- Provides a byte-enabled word RAM with same-cycle read and clock-edge write.
- Adds an out-of-range error flag and, optionally, a store-trace FIFO drained by a valid/ready consumer (bench monitor or debug port).
- Instantiated beside the CPU top in the system/tb wrapper.

Parameters:
- ADDR_W, 12, word-address width; RAM holds 2^ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
- TRACE_DEPTH, 8, store-trace FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m_data_addr  in  32  byte address from M stage
- m_data_wdata  in  32  store data, already lane-aligned by the CPU
- m_data_byteen  in  4  byte write enables; 4'b0000 means read or idle
- m_inst_addr  in  32  PC of the M-stage instruction
- m_data_rdata  out  32  read word, combinational
- err_oor  out  1  sticky out-of-range flag
- trace_valid  out  1  trace entry available
- trace_ready  in  1  consumer accepts entry
- trace_pc  out  32  PC of the traced store
- trace_addr  out  32  word-aligned byte address
- trace_wdata  out  32  resulting word after merge
- trace_byteen  out  4  enables of the store
- trace_drop  out  8  saturating count of stores dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock is used throughout; reset is synchronous and active-high.
- Addressing:
  - off = m_data_addr - BASE_ADDR.
  - Index = off[ADDR_W+1:2].
  - In range iff m_data_addr >= BASE_ADDR and off[31:ADDR_W+2] == 0.
  - Bits [1:0] are ignored; the CPU handles alignment.
- Read:
  - m_data_rdata = mem[index] when in range, else 0. No latency.
  - Always returns the pre-edge contents, so a same-cycle store is not visible.
- Write:
  - At posedge, for each i with byteen[i]=1 and the address in range, mem[index][8i+7:8i] <= wdata[8i+7:8i].
  - Other bytes are unchanged.
- Out of range:
  - Any access out of range (read or write) sets err_oor at the next edge; the write is ignored.
  - err_oor stays set until reset.
- Reset:
  - All words clear to 0 at the reset edge.
  - err_oor=0, trace_valid=0, trace_drop=0, FIFO pointers=0, trace_* data=0.
  - Reset asserted mid-write wins; the write is discarded.
- Trace FIFO:
  - Push on any in-range write with byteen!=0. Entry = {m_inst_addr, word-aligned addr, merged word (old bytes combined with new), byteen}.
  - Pop when trace_valid && trace_ready.
  - Output is first-word-fall-through: head entry drives trace_* while trace_valid=1.
  - trace_valid = count!=0. The count register spans 0..TRACE_DEPTH; pointers wrap modulo TRACE_DEPTH.
  - Full with push and no pop: entry dropped, trace_drop++ (saturates at 255), count unchanged.
  - Full with push and pop in the same cycle: both happen, no drop.
  - Empty with push and pop: the pop is not possible since trace_valid=0; the push is accepted.
  - trace_* outputs are held stable while trace_valid && !trace_ready.

Optional Feature:
- Macro DMEM_TRACE_EN.
- Defined: the trace FIFO and drop counter are built as described above.
- Undefined: no FIFO storage is built. trace_valid, trace_pc, trace_addr, trace_wdata, trace_byteen and trace_drop are tied to 0, and trace_ready is ignored. RAM and err_oor behaviour are identical in both builds.

Decomposition:
- Shared package/header holds:
  - byte-enable constants: BE_WORD=4'b1111, BE_NONE=4'b0000, halfword masks, byte masks;
  - trace entry width constant TRACE_W=100;
  - the default base address constant.
- One sub-module, trace_fifo: a generic FWFT FIFO with parameters WIDTH and DEPTH and ports push/pop/full/empty/count. The drop counter stays in dm_responder.

Test Plan:
1. Reset, then read 0x0000_0010 -> rdata=0. Store word 0x1234_5678 at 0x10 with be=1111 -> next-cycle read returns 0x1234_5678; trace entry pc/addr=0x10/0x1234_5678/1111.
2. Byte store be=0010, wdata=0x0000_AB00 at 0x10 -> word becomes 0x1234_AB78; same-cycle read during the store still returns 0x1234_5678.
3. Out-of-range store to 0x0000_4000 (ADDR_W=12) -> RAM unchanged, err_oor=1 at the next edge and held; no trace push.
4. trace_ready=0, 9 consecutive stores, TRACE_DEPTH=8 -> 8 entries kept in order, trace_drop=1. Then one store with trace_ready=1 while full -> no drop; count stays 8.
5. Drain the FIFO -> entries emerge in push order with stable data while stalled by trace_ready; trace_valid falls after the last pop.
6. Reset asserted in the same cycle as a store -> store discarded, memory 0, err_oor=0, trace_drop=0, trace_valid=0. Build without DMEM_TRACE_EN -> all trace outputs 0.

Source files
------------

// File: rtl/dm_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dm_responder_pkg                                                |
// | Purpose  : Shared constants, trace-entry layout and byte-merge helper for  |
// |            the data-memory responder and its trace FIFO.                   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dm_responder_pkg;

  // Byte-enable patterns as produced by the CPU store aligner.
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;

  // pc(32) + addr(32) + merged word(32) + byteen(4)
  localparam int TRACE_W = 100;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } trace_entry_t;

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byteen);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byteen[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_responder_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trace_fifo                                                      |
// | Purpose  : Generic first-word-fall-through FIFO. The head entry is always  |
// |            visible on data_o; a pop advances to the next entry.            |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            push_i/data_i   - write side (ignored when full unless popping) |
// |            pop_i           - read side (ignored when empty)                |
// |            data_o          - head entry                                    |
// |            full_o/empty_o/count_o - occupancy status                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module trace_fifo #(
  parameter  int WIDTH = 100,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;   // DEPTH is a power of two: wraps naturally
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dm_responder                                                    |
// | Purpose  : Slave end of the CPU M-stage data port. Byte-enabled word RAM   |
// |            with combinational read and edge write, sticky out-of-range    |
// |            flag, and an optional store-trace FIFO (macro DMEM_TRACE_EN).  |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            m_data_addr/wdata/byteen, m_inst_addr - M-stage request         |
// |            m_data_rdata  - read word (pre-edge contents, 0 out of range)  |
// |            err_oor       - sticky out-of-range flag                        |
// |            trace_valid/ready, trace_pc/addr/wdata/byteen - store trace    |
// |            trace_drop    - saturating count of stores lost to a full FIFO |
// | Config   : DMEM_TRACE_EN defined   -> trace FIFO and drop counter built    |
// |            DMEM_TRACE_EN undefined -> trace outputs tied to 0             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        err_oor,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_wdata,
  output logic [3:0]  trace_byteen,
  output logic [7:0]  trace_drop
);

  localparam int WORDS = 1 << ADDR_W;

  logic [31:0]       mem_q [WORDS];
  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] index;
  logic [31:0]       cur_word;
  logic [31:0]       merged_word;
  logic              wr_en;
  logic              err_oor_q;
  logic              err_oor_d;

  // The subtraction can wrap below BASE_ADDR, hence the explicit >= test.
  assign off         = m_data_addr - BASE_ADDR;
  assign in_range    = (m_data_addr >= BASE_ADDR) && (off[31:ADDR_W+2] == '0);
  assign index       = off[ADDR_W+1:2];
  assign cur_word    = mem_q[index];
  assign merged_word = merge_bytes(cur_word, m_data_wdata, m_data_byteen);
  assign wr_en       = in_range && (m_data_byteen != BE_NONE);

  assign m_data_rdata = in_range ? cur_word : '0;

  // The port has no request strobe, so every cycle's address counts as an
  // access; the CPU parks the address in range while idle.
  assign err_oor_d = err_oor_q | ~in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
      err_oor_q <= 1'b0;
    end else begin
      if (wr_en) mem_q[index] <= merged_word;
      err_oor_q <= err_oor_d;
    end
  end

  assign err_oor = err_oor_q;

`ifdef DMEM_TRACE_EN
  localparam int CNT_W = $clog2(TRACE_DEPTH + 1);

  trace_entry_t       push_entry;
  trace_entry_t       head_entry;
  logic [TRACE_W-1:0] head_bits;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [CNT_W-1:0]   fifo_count;
  logic [7:0]         drop_q;
  logic [7:0]         drop_d;
  logic               unused_trace;

  // The traced word is the post-merge value, i.e. what the RAM holds after the edge.
  assign push_entry = '{pc:     m_inst_addr,
                        addr:   {m_data_addr[31:2], 2'b00},
                        wdata:  merged_word,
                        byteen: m_data_byteen};

  assign fifo_pop = !fifo_empty && trace_ready;

  trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_en),
    .pop_i   (fifo_pop),
    .data_i  (push_entry),
    .data_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_entry = trace_entry_t'(head_bits);

  always_comb begin
    drop_d = drop_q;
    if (wr_en && fifo_full && !fifo_pop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign trace_valid  = !fifo_empty;
  assign trace_pc     = head_entry.pc;
  assign trace_addr   = head_entry.addr;
  assign trace_wdata  = head_entry.wdata;
  assign trace_byteen = head_entry.byteen;
  assign trace_drop   = drop_q;

  // Occupancy is only needed inside the FIFO; full/empty suffice here.
  assign unused_trace = ^fifo_count;
`else
  logic unused_notrace;

  assign trace_valid  = 1'b0;
  assign trace_pc     = '0;
  assign trace_addr   = '0;
  assign trace_wdata  = '0;
  assign trace_byteen = '0;
  assign trace_drop   = '0;

  assign unused_notrace = ^{trace_ready, m_inst_addr};
`endif

  // Byte offset within the word is the CPU's concern; the lane masks are
  // shared with the CPU-side store aligner and not decoded here.
  logic unused_common;
  assign unused_common = ^{off[1:0], BE_WORD, BE_HALF_LO, BE_HALF_HI,
                           BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3};

endmodule
`default_nettype wire
